// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the npc fetch sequencer: state encoding, bus widths,
// boot address and redirect polarity.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_e;

  localparam int          INST_ADDR_BUS_W = 32;
  localparam int          INST_BUS_W      = 32;
  localparam logic [31:0] RESET_PC_DEF    = 32'h8000_0000;
  localparam logic        BRANCH_TAKEN    = 1'b1;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time and
// hands each instruction to decode; redirects discard wrong-path responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                DATA_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_drop;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;

  fetch_state_e      w_state_nxt;
  logic              w_drop_nxt;
  logic              w_capture;
  logic              w_take_redirect;
  logic              w_advance;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_tgt;
  logic [ADDR_W-1:0] w_pc_nxt;

  assign w_redirect     = (redirect_valid == BRANCH_TAKEN);
  assign w_redirect_tgt = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    w_state_nxt     = r_state;
    w_drop_nxt      = r_drop;
    w_capture       = 1'b0;
    w_take_redirect = 1'b0;
    w_advance       = 1'b0;
    unique case (r_state)
      FETCH_BOOT: w_state_nxt = FETCH_REQ;
      FETCH_REQ: begin
        // A redirect coinciding with grant lets the old address go out; its response is dropped.
        if (w_redirect) begin
          w_take_redirect = 1'b1;
          if (imem_gnt) w_drop_nxt = 1'b1;
        end
        if (imem_gnt) w_state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = FETCH_REQ;
          if (w_redirect) begin
            w_take_redirect = 1'b1;
          end else if (!r_drop) begin
            w_capture   = 1'b1;
            w_state_nxt = FETCH_HOLD;
          end
        end else if (w_redirect) begin
          w_take_redirect = 1'b1;
          w_drop_nxt      = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (w_redirect) begin
          w_take_redirect = 1'b1;
          w_state_nxt     = FETCH_REQ;
        end else if (inst_ready) begin
          w_advance   = 1'b1;
          w_state_nxt = FETCH_REQ;
        end
      end
      default: w_state_nxt = FETCH_BOOT;
    endcase
  end

  // Next-pc mux; sequential increment wraps naturally modulo 2^ADDR_W.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_take_redirect) w_pc_nxt = w_redirect_tgt;
    else if (w_advance)  w_pc_nxt = r_pc + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= FETCH_BOOT;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the instruction buffer is reset too, so decode never sees X on inst/inst_pc after boot.
    if (rst) begin
      r_inst    <= '0;
      r_inst_pc <= RESET_PC;
    end else if (w_capture) begin
      r_inst    <= imem_rdata;
      r_inst_pc <= r_pc;
    end
  end

  assign imem_req   = (r_state == FETCH_REQ);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == FETCH_HOLD) && !w_redirect;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule
